// File: rtl/core_pkg.sv
// ============================================================================
//  Module   : core_pkg
//  Purpose  : Shared instruction-word field map, idle word and sequencer states.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    localparam int INST_W     = 35;
    localparam int ADDR_W     = 11;

    localparam int RELU_B     = 34;
    localparam int ACC_B      = 33;
    localparam int CEN_PMEM_B = 32;
    localparam int WEN_PMEM_B = 31;
    localparam int A_PMEM_HI  = 30;
    localparam int A_PMEM_LO  = 20;
    localparam int CEN_XMEM_B = 19;
    localparam int WEN_XMEM_B = 18;
    localparam int A_XMEM_HI  = 17;
    localparam int A_XMEM_LO  = 7;
    localparam int OFIFO_RD_B = 6;
    localparam int IFIFO_WR_B = 5;
    localparam int IFIFO_RD_B = 4;
    localparam int L0_RD_B    = 3;
    localparam int L0_WR_B    = 2;
    localparam int EXECUTE_B  = 1;
    localparam int LOAD_B     = 0;

    // Both SRAMs deselected and write-disabled; every other control low.
    localparam logic [INST_W-1:0] INST_IDLE = 35'h1_800C_0000;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_KW_L0  = 4'd1,
        ST_KLOAD  = 4'd2,
        ST_GAP    = 4'd3,
        ST_ACT_L0 = 4'd4,
        ST_EXEC   = 4'd5,
        ST_OFIFO  = 4'd6,
        ST_CLR    = 4'd7,
        ST_RD     = 4'd8,
        ST_TAIL   = 4'd9
    } state_t;

endpackage

`default_nettype wire

// File: rtl/conv_addr_gen.sv
// ============================================================================
//  Module   : conv_addr_gen
//  Purpose  : Input-pixel index for (output pixel, kernel tap) using wrapping
//             counters and incrementally maintained row products.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_addr_gen #(
    parameter int I_WIDTH = 6,
    parameter int O_WIDTH = 4,
    parameter int K_WIDTH = 3,
    parameter int ADDR_W  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_nij
);

    localparam int KW = $clog2(K_WIDTH + 1);
    localparam int OW = $clog2(O_WIDTH + 1);
    localparam logic [KW-1:0]     c_k_max = KW'(K_WIDTH - 1);
    localparam logic [OW-1:0]     c_o_max = OW'(O_WIDTH - 1);
    localparam logic [ADDR_W-1:0] c_i_w   = ADDR_W'(I_WIDTH);

    logic [KW-1:0]     r_kcol, r_krow;
    logic [OW-1:0]     r_ocol, r_orow;
    logic [ADDR_W-1:0] r_krow_off, r_row_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kcol     <= '0;
            r_krow     <= '0;
            r_ocol     <= '0;
            r_orow     <= '0;
            r_krow_off <= '0;
            r_row_base <= '0;
        end else if (i_clr) begin
            r_kcol     <= '0;
            r_krow     <= '0;
            r_ocol     <= '0;
            r_orow     <= '0;
            r_krow_off <= '0;
            r_row_base <= '0;
        end else if (i_step) begin
            // Kernel column wraps into kernel row, which wraps into the next output pixel.
            if (r_kcol != c_k_max) begin
                r_kcol <= r_kcol + 1'b1;
            end else begin
                r_kcol <= '0;
                if (r_krow != c_k_max) begin
                    r_krow     <= r_krow + 1'b1;
                    r_krow_off <= r_krow_off + c_i_w;
                end else begin
                    r_krow     <= '0;
                    r_krow_off <= '0;
                    if (r_ocol != c_o_max) begin
                        r_ocol <= r_ocol + 1'b1;
                    end else begin
                        r_ocol <= '0;
                        if (r_orow != c_o_max) begin
                            r_orow     <= r_orow + 1'b1;
                            r_row_base <= r_row_base + c_i_w;
                        end else begin
                            r_orow     <= '0;
                            r_row_base <= '0;
                        end
                    end
                end
            end
        end
    end

    assign o_nij = r_row_base + r_krow_off + ADDR_W'(r_ocol) + ADDR_W'(r_kcol);

endmodule

`default_nettype wire

// File: rtl/core_inst_seq.sv
// ============================================================================
//  Module   : core_inst_seq
//  Purpose  : Generates the core instruction word for one kij pass (mode 0)
//             or the full pmem accumulation sweep (mode 1).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_inst_seq
    import core_pkg::*;
#(
    parameter int COL        = 8,
    parameter int LEN_NIJ    = 36,
    parameter int LEN_ONIJ   = 16,
    parameter int LEN_KIJ    = 9,
    parameter int I_WIDTH    = 6,
    parameter int O_WIDTH    = 4,
    parameter int K_WIDTH    = 3,
    parameter int W_BASE     = 1024,
    parameter int P_BASE     = 0,
    parameter int GAP_CYCLES = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [3:0]        kij,
    input  logic              relu_en,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              core_clr,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(LEN_NIJ + 2);
    localparam int OW = $clog2(LEN_ONIJ + 1);
    localparam logic [CW-1:0] c_col      = CW'(COL);
    localparam logic [CW-1:0] c_col_m1   = CW'(COL - 1);
    localparam logic [CW-1:0] c_nij      = CW'(LEN_NIJ);
    localparam logic [CW-1:0] c_nij_m1   = CW'(LEN_NIJ - 1);
    localparam logic [CW-1:0] c_gap_m1   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] c_kij_m1   = CW'(LEN_KIJ - 1);
    localparam logic [OW-1:0] c_onij_m1  = OW'(LEN_ONIJ - 1);
    localparam logic [4:0]    c_kij_lim  = 5'(LEN_KIJ);

    state_t            r_state, w_nstate;
    logic [CW-1:0]     r_cnt, w_ncnt, r_wr_cnt;
    logic [3:0]        r_kij, w_kij_eff;
    logic [OW-1:0]     r_onij;
    logic [ADDR_W-1:0] r_kofs, w_nij, w_wbase, w_pbase;
    logic [INST_W-1:0] r_inst, w_inst_nxt;
    logic              r_core_clr, r_busy, r_done;
    logic              w_rd, w_done_nxt, w_start_ok, w_gen_clr, w_gen_step;

    assign w_start_ok = start && !r_done && (mode || ({1'b0, kij} < c_kij_lim));
    assign w_kij_eff  = (r_state == ST_IDLE) ? kij : r_kij;
    assign w_wbase    = ADDR_W'(W_BASE) + ADDR_W'(w_kij_eff * COL);
    assign w_pbase    = ADDR_W'(P_BASE) + ADDR_W'(r_kij * LEN_NIJ);
    // The OFIFO pop must track ofifo_valid in the same cycle, so it bypasses the register.
    assign w_rd       = (r_state == ST_OFIFO) && ofifo_valid && (r_cnt < c_nij);
    assign w_gen_clr  = (r_state == ST_IDLE);
    assign w_gen_step = (w_nstate == ST_RD);

    conv_addr_gen #(
        .I_WIDTH (I_WIDTH),
        .O_WIDTH (O_WIDTH),
        .K_WIDTH (K_WIDTH),
        .ADDR_W  (ADDR_W)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (reset),
        .i_clr  (w_gen_clr),
        .i_step (w_gen_step),
        .o_nij  (w_nij)
    );

    always_comb begin
        w_nstate   = r_state;
        w_ncnt     = r_cnt + 1'b1;
        w_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ncnt = '0;
                if (w_start_ok) w_nstate = mode ? ST_CLR : ST_KW_L0;
            end
            ST_KW_L0:  if (r_cnt == c_col)    begin w_nstate = ST_KLOAD;  w_ncnt = '0; end
            ST_KLOAD:  if (r_cnt == c_col_m1) begin w_nstate = ST_GAP;    w_ncnt = '0; end
            ST_GAP:    if (r_cnt == c_gap_m1) begin w_nstate = ST_ACT_L0; w_ncnt = '0; end
            ST_ACT_L0: if (r_cnt == c_nij)    begin w_nstate = ST_EXEC;   w_ncnt = '0; end
            ST_EXEC:   if (r_cnt == c_nij_m1) begin w_nstate = ST_OFIFO;  w_ncnt = '0; end
            ST_OFIFO: begin
                w_ncnt = r_cnt + CW'(w_rd);
                if (r_wr_cnt == c_nij) begin
                    w_nstate   = ST_IDLE;
                    w_ncnt     = '0;
                    w_done_nxt = 1'b1;
                end
            end
            ST_CLR: begin
                w_nstate = ST_RD;
                w_ncnt   = '0;
            end
            ST_RD: if (r_cnt == c_kij_m1) begin w_nstate = ST_TAIL; w_ncnt = '0; end
            ST_TAIL: begin
                w_ncnt = '0;
                if (r_onij == c_onij_m1) begin
                    w_nstate   = ST_IDLE;
                    w_done_nxt = 1'b1;
                end else begin
                    w_nstate = ST_CLR;
                end
            end
            default: begin
                w_nstate = ST_IDLE;
                w_ncnt   = '0;
            end
        endcase
    end

    // Word for the cycle about to start, built from the next state and count.
    always_comb begin
        w_inst_nxt = INST_IDLE;
        case (w_nstate)
            ST_KW_L0: begin
                if (w_ncnt < c_col) begin
                    w_inst_nxt[CEN_XMEM_B]           = 1'b0;
                    w_inst_nxt[A_XMEM_HI:A_XMEM_LO]  = w_wbase + ADDR_W'(w_ncnt);
                end
                w_inst_nxt[L0_WR_B] = (w_ncnt != '0);
            end
            ST_ACT_L0: begin
                if (w_ncnt < c_nij) begin
                    w_inst_nxt[CEN_XMEM_B]           = 1'b0;
                    w_inst_nxt[A_XMEM_HI:A_XMEM_LO]  = ADDR_W'(w_ncnt);
                end
                w_inst_nxt[L0_WR_B] = (w_ncnt != '0);
            end
            ST_KLOAD: begin
                w_inst_nxt[L0_RD_B] = 1'b1;
                w_inst_nxt[LOAD_B]  = 1'b1;
            end
            ST_EXEC: begin
                w_inst_nxt[L0_RD_B]   = 1'b1;
                w_inst_nxt[EXECUTE_B] = 1'b1;
            end
            ST_RD: begin
                w_inst_nxt[CEN_PMEM_B]          = 1'b0;
                w_inst_nxt[A_PMEM_HI:A_PMEM_LO] = ADDR_W'(P_BASE) + r_kofs + w_nij;
                w_inst_nxt[ACC_B]               = (w_ncnt != '0);
                w_inst_nxt[RELU_B]              = relu_en;
            end
            ST_TAIL: begin
                w_inst_nxt[ACC_B]  = 1'b1;
                w_inst_nxt[RELU_B] = relu_en;
            end
            default: ;
        endcase
        if (w_rd) begin
            w_inst_nxt[CEN_PMEM_B]          = 1'b0;
            w_inst_nxt[WEN_PMEM_B]          = 1'b0;
            w_inst_nxt[A_PMEM_HI:A_PMEM_LO] = w_pbase + ADDR_W'(r_wr_cnt);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_wr_cnt   <= '0;
            r_kij      <= '0;
            r_onij     <= '0;
            r_kofs     <= '0;
            r_inst     <= INST_IDLE;
            r_core_clr <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_nstate;
            r_cnt      <= w_ncnt;
            r_inst     <= w_inst_nxt;
            r_core_clr <= (w_nstate == ST_CLR);
            r_busy     <= (w_nstate != ST_IDLE);
            r_done     <= w_done_nxt;
            if (r_state == ST_IDLE && w_start_ok) r_kij <= kij;
            if (r_state == ST_OFIFO) r_wr_cnt <= r_wr_cnt + CW'(w_rd);
            else                     r_wr_cnt <= '0;
            if (r_state == ST_IDLE)      r_onij <= '0;
            else if (r_state == ST_TAIL) r_onij <= r_onij + 1'b1;
            // Tap offset k*LEN_NIJ tracks the tap issued on the next RD cycle.
            if (w_nstate == ST_RD)
                r_kofs <= (w_ncnt == c_kij_m1) ? '0 : r_kofs + ADDR_W'(LEN_NIJ);
            else if (r_state == ST_IDLE)
                r_kofs <= '0;
        end
    end

    always_comb begin
        inst             = r_inst;
        inst[OFIFO_RD_B] = w_rd;
    end

    assign core_clr = r_core_clr;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_core_inst_seq.sv
// ============================================================================
//  Module   : tb_core_inst_seq
//  Purpose  : Scoreboard bench for core_inst_seq: expected SRAM accesses are
//             queued by the stimulus and popped by an independent monitor.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_inst_seq;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [3:0]  kij = 4'd0;
    logic        relu_en = 1'b0;
    logic        ofifo_valid = 1'b0;
    logic [34:0] inst;
    logic        core_clr, busy, done;

    core_inst_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .kij         (kij),
        .relu_en     (relu_en),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .core_clr    (core_clr),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] a;
        logic        wen;
        logic        acc;
        logic        relu;
    } pexp_t;

    logic [10:0] q_x[$];
    pexp_t       q_p[$];
    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_clr  = 0;
    int n_acc  = 0;
    logic mon_en   = 1'b0;
    logic tog      = 1'b0;
    logic exp_relu = 1'b0;
    logic prev_rd  = 1'b0;

    int pbase [16] = '{0, 1, 2, 3, 6, 7, 8, 9, 12, 13, 14, 15, 18, 19, 20, 21};
    int koff  [9]  = '{0, 1, 2, 6, 7, 8, 12, 13, 14};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (tog) ofifo_valid = ~ofifo_valid;
    end

    // Monitor: pops expectations whenever the DUT enables an SRAM.
    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (!inst[CEN_XMEM_B]) begin
                if (q_x.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL xmem_unexpected actual=%0d required=none", inst[A_XMEM_HI:A_XMEM_LO]);
                end else begin
                    chk("xmem_addr", 64'(inst[A_XMEM_HI:A_XMEM_LO]), 64'(q_x.pop_front()));
                    chk("xmem_wen", 64'(inst[WEN_XMEM_B]), 64'd1);
                end
            end
            if (!inst[CEN_PMEM_B]) begin
                chk("cen_exclusive", 64'(inst[CEN_XMEM_B]), 64'd1);
                if (q_p.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pmem_unexpected actual=%0d required=none", inst[A_PMEM_HI:A_PMEM_LO]);
                end else begin
                    pexp_t e;
                    e = q_p.pop_front();
                    chk("pmem_addr", 64'(inst[A_PMEM_HI:A_PMEM_LO]), 64'(e.a));
                    chk("pmem_wen", 64'(inst[WEN_PMEM_B]), 64'(e.wen));
                    chk("pmem_acc", 64'(inst[ACC_B]), 64'(e.acc));
                    chk("pmem_relu", 64'(inst[RELU_B]), 64'(e.relu));
                    if (!inst[WEN_PMEM_B]) chk("wr_after_rd", 64'(prev_rd), 64'd1);
                end
            end
            if (inst[OFIFO_RD_B]) chk("ofifo_rd_valid", 64'(ofifo_valid), 64'd1);
            if (inst[ACC_B] && inst[CEN_PMEM_B]) chk("tail_relu", 64'(inst[RELU_B]), 64'(exp_relu));
            if (done)       n_done++;
            if (core_clr)   n_clr++;
            if (inst[ACC_B]) n_acc++;
            prev_rd = inst[OFIFO_RD_B];
        end
    end

    task automatic issue(input logic m, input logic [3:0] k);
        @(negedge clk);
        start = 1'b1; mode = m; kij = k;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input logic poke, output int cyc);
        cyc = 0;
        while (!done && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 50) begin start = 1'b1; mode = 1'b1; end
            if (poke && cyc == 51) start = 1'b0;
        end
        chk("done_seen", 64'(done), 64'd1);
    endtask

    task automatic push_mode0(input int k);
        pexp_t e;
        for (int t = 0; t < 8; t++)  q_x.push_back(11'(1024 + k * 8 + t));
        for (int t = 0; t < 36; t++) q_x.push_back(11'(t));
        for (int n = 0; n < 36; n++) begin
            e.a = 11'(k * 36 + n); e.wen = 1'b0; e.acc = 1'b0; e.relu = 1'b0;
            q_p.push_back(e);
        end
    endtask

    task automatic finish_run(input string name);
        repeat (3) @(negedge clk);
        chk({name, "_xq_empty"}, 64'(q_x.size()), 64'd0);
        chk({name, "_pq_empty"}, 64'(q_p.size()), 64'd0);
        chk({name, "_done_once"}, 64'(n_done), 64'd1);
        chk({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int cyc;
        pexp_t e;
        repeat (2) @(negedge clk);
        chk("rst_inst", 64'(inst), 64'h1_800C_0000);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_clr", 64'(core_clr), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_inst", 64'(inst), 64'h1_800C_0000);
        mon_en = 1'b1;

        // Mode 0, kij=2, valid held high; start coincident with done is dropped.
        ofifo_valid = 1'b1; n_done = 0;
        push_mode0(2);
        issue(1'b0, 4'd2);
        wait_done(400, 1'b0, cyc);
        chk("m0_done_cycle", 64'(cyc), 64'd137);
        start = 1'b1; mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_on_done_ignored", 64'(busy), 64'd0);
        chk("done_one_cycle", 64'(done), 64'd0);
        finish_run("m0k2");

        // Mode 0, kij=0, valid toggling, start poked while busy.
        n_done = 0; tog = 1'b1;
        push_mode0(0);
        issue(1'b0, 4'd0);
        wait_done(400, 1'b1, cyc);
        tog = 1'b0; ofifo_valid = 1'b1;
        finish_run("m0k0");

        // Mode 1 sweep with relu on and off.
        for (int r = 1; r >= 0; r--) begin
            n_done = 0; n_clr = 0; n_acc = 0;
            relu_en = 1'(r); exp_relu = 1'(r);
            for (int o = 0; o < 16; o++)
                for (int k = 0; k < 9; k++) begin
                    e.a = 11'(k * 36 + pbase[o] + koff[k]);
                    e.wen = 1'b1; e.acc = (k != 0); e.relu = 1'(r);
                    q_p.push_back(e);
                end
            issue(1'b1, 4'd0);
            wait_done(400, 1'b0, cyc);
            chk("m1_done_cycle", 64'(cyc), 64'd176);
            chk("m1_clr_pulses", 64'(n_clr), 64'd16);
            chk("m1_acc_cycles", 64'(n_acc), 64'd144);
            finish_run("m1");
        end

        // Out-of-range kij is rejected in IDLE.
        n_done = 0;
        issue(1'b0, 4'd9);
        repeat (20) @(negedge clk);
        chk("kij9_busy", 64'(busy), 64'd0);
        chk("kij9_done", 64'(n_done), 64'd0);
        chk("kij9_inst", 64'(inst), 64'h1_800C_0000);

        // Upper valid kij.
        n_done = 0;
        push_mode0(8);
        issue(1'b0, 4'd8);
        wait_done(400, 1'b0, cyc);
        finish_run("m0k8");

        // Reset asserted mid-EXEC.
        mon_en = 1'b0;
        issue(1'b0, 4'd1);
        repeat (69) @(negedge clk);
        chk("in_exec", 64'(inst[EXECUTE_B]), 64'd1);
        #1 reset = 1'b0;
        #1;
        chk("async_rst_inst", 64'(inst), 64'h1_800C_0000);
        chk("async_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_inst", 64'(inst), 64'h1_800C_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
